debug_uart_responder: RTL
=========================

// Module: debug_uart_responder
// PURPOSE
//   UART debug target inside the CPU. A host sends command frames on uart_rx.
//   The block reads the register file, the PC or RAM through read-only taps,
//   then returns the 32-bit value on uart_tx.
//   It gives on-hardware access to the same state the simulation bench inspects (a0..a3, ra, pc, ram[]).
//   It sits beside regs_i/pc_i/ram_i in CPU and never writes CPU state.
// PARAMETERS
//   CLKS_PER_BIT    868     i_clk cycles per UART bit (8N1); must be >= 4
//   TIMEOUT_CYCLES  100000  max idle gap between operand bytes before the frame is abandoned
// PORTS
//   i_clk           in   1   system clock
//   i_rst           in   1   asynchronous, active-high reset
//   uart_rx         in   1   host->target serial, idle high, asynchronous to i_clk
//   uart_tx         out  1   target->host serial, idle high
//   dbg_reg_addr    out  5   register file tap index
//   dbg_reg_rdata   in   32  registers[dbg_reg_addr], combinational
//   dbg_pc          in   32  current pc
//   dbg_mem_req     out  1   RAM read request, held until ack
//   dbg_mem_addr    out  32  byte address, word aligned (bits [1:0] forced 0)
//   dbg_mem_ack     in   1   one-cycle pulse: dbg_mem_rdata valid
//   dbg_mem_rdata   in   32  RAM word
//   o_busy          out  1   high whenever the FSM is not in IDLE
// BEHAVIOUR
//   Reset: uart_tx=1; dbg_mem_req=0; dbg_mem_addr=0; dbg_reg_addr=0; o_busy=0; FSM=IDLE; UART counters cleared.
//   A reset mid-frame abandons the frame. Any TX byte in progress is cut and the line returns high.
//   RX
//   - uart_rx passes through a 2-flop synchroniser.
//   - A falling edge in RX idle starts a byte. The line is re-checked at CLKS_PER_BIT/2; if high, the start is false and is ignored.
//   - Data bits are sampled at bit centres, LSB first.
//   - If the stop bit is 0, this is a framing error: the byte is dropped and the FSM is unaffected.
//   - A good byte raises an internal rx_valid for exactly 1 cycle.
//   TX
//   - 8N1, LSB first. Each bit lasts exactly CLKS_PER_BIT cycles.
//   - Bytes in a response are sent back to back, with no idle bits between stop and the next start.
//   Commands (all responses are little-endian, 4 bytes unless noted)
//   - 0x01 RDREG: 1 operand byte; index = byte[4:0], bits [7:5] ignored. Reply: registers[index].
//   - 0x02 RDMEM: 4 operand bytes = address, LSB first. Reply: RAM word at address & ~3.
//   - 0x03 RDPC:  no operands. Reply: dbg_pc.
//   - 0x7E PING:  no operands. Reply: one byte, 0xA5.
//   - Any other command byte: reply one byte, 0xEE.
//   FSM: IDLE -> OPERAND -> FETCH -> SEND -> IDLE
//   - IDLE: on rx_valid, latch the opcode. Go to OPERAND if the command has operands, otherwise go to FETCH.
//   - OPERAND: shift in operand bytes. A gap counter resets on every rx_valid. If the gap reaches TIMEOUT_CYCLES, go to IDLE with no reply.
//   - FETCH, RDREG: drive dbg_reg_addr, capture dbg_reg_rdata 1 cycle later.
//   - FETCH, RDPC: capture dbg_pc in the FETCH cycle.
//   - FETCH, RDMEM: assert dbg_mem_req with dbg_mem_addr stable. Capture dbg_mem_rdata on dbg_mem_ack and drop req in the next cycle. No timeout on ack.
//   - SEND: transmit the response bytes. After the stop bit of the last byte, go to IDLE.
//   - RX bytes arriving while in FETCH or SEND are discarded. There is no queueing.
//   Latency: the reply start bit begins within 3 cycles of the final operand's rx_valid for RDREG/RDPC, and within 3 cycles of dbg_mem_ack for RDMEM.
//   Snapshot: the captured value is frozen for the whole response, even if CPU state changes.
// TESTING (CLKS_PER_BIT=4, TIMEOUT_CYCLES=200)
//   1 Preload registers[10]=0x12345678; send 01 0A -> tx 78 56 34 12; o_busy high from opcode until the last stop bit.
//   2 Model RAM: ram[1]=0xDEADBEEF, ack 5 cycles after req; send 02 07 00 00 00 -> dbg_mem_addr=0x4; tx EF BE AD DE; req falls the cycle after ack.
//   3 dbg_pc=0x00000040: send 03 -> 40 00 00 00. Send 7E -> A5. Send 55 -> EE.
//   4 Send 02 10, then idle 250 cycles, then 03 -> no reply to the partial RDMEM; RDPC answers normally.
//   5 A frame with stop bit=0, then a 2-cycle low glitch on uart_rx -> no rx_valid, FSM stays IDLE; a following 7E -> A5.
//   6 Assert i_rst mid-SEND of test 1 -> uart_tx=1 immediately, o_busy=0; the next 01 0A is answered correctly.

Source files
------------

// File: rtl/debug_uart_responder_if.sv
// Read-only debug taps between the UART responder and the CPU state it inspects.
// The responder is the master: it drives the indices and requests, and the CPU side answers.
interface debug_uart_responder_if;
   logic [4:0]  dbg_reg_addr;
   logic [31:0] dbg_reg_rdata;
   logic [31:0] dbg_pc;
   logic        dbg_mem_req;
   logic [31:0] dbg_mem_addr;
   logic        dbg_mem_ack;
   logic [31:0] dbg_mem_rdata;

   modport master (
      output dbg_reg_addr, dbg_mem_req, dbg_mem_addr,
      input  dbg_reg_rdata, dbg_pc, dbg_mem_ack, dbg_mem_rdata
   );
   modport slave (
      input  dbg_reg_addr, dbg_mem_req, dbg_mem_addr,
      output dbg_reg_rdata, dbg_pc, dbg_mem_ack, dbg_mem_rdata
   );
endinterface

// File: rtl/debug_uart_responder.sv
// UART debug target: decodes host command frames, reads regs/pc/RAM through taps,
// and streams the captured 32-bit value back as 8N1 bytes, little-endian.
module debug_uart_responder #(
   parameter int CLKS_PER_BIT   = 868,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          uart_rx,
   output logic                          uart_tx,
   output logic                          o_busy,
   debug_uart_responder_if.master        dbg
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [GW-1:0] GAP_END  = GW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] CMD_RDREG = 8'h01;
   localparam logic [7:0] CMD_RDMEM = 8'h02;
   localparam logic [7:0] CMD_RDPC  = 8'h03;
   localparam logic [7:0] CMD_PING  = 8'h7E;

   typedef enum logic [1:0] {S_IDLE, S_OPERAND, S_FETCH, S_SEND} state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
   rx_state_t       rx_st_q, rx_st_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;

   state_t          state_q, state_d;
   logic [7:0]      opcode_q, opcode_d;
   logic [1:0]      op_cnt_q, op_cnt_d;
   logic [23:0]     op_buf_q, op_buf_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [4:0]      reg_addr_q, reg_addr_d;
   logic            mem_req_q, mem_req_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [23:0]     resp_q, resp_d;
   logic [1:0]      left_q, left_d;
   logic [9:0]      frame_q, frame_d;
   logic [3:0]      tx_bit_q, tx_bit_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic            uart_tx_q, uart_tx_d, busy_q, busy_d;

   logic            fetch_go;
   logic [31:0]     fetch_val;
   logic [1:0]      fetch_left;

   // Receiver: start is qualified at half a bit, then every bit is sampled at its centre.
   always_comb begin
      rx_s1_d    = uart_rx;
      rx_s2_d    = rx_s1_q;
      rx_s3_d    = rx_s2_q;
      rx_st_d    = rx_st_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (rx_st_q)
         R_IDLE: if (rx_s3_q && !rx_s2_q) begin
            rx_st_d  = R_START;
            rx_cnt_d = '0;
         end
         R_START: if (rx_cnt_q == HALF_END) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
         end else rx_cnt_d = rx_cnt_q + 1'b1;
         R_DATA: if (rx_cnt_q == BIT_END) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
         end else rx_cnt_d = rx_cnt_q + 1'b1;
         default: if (rx_cnt_q == BIT_END) begin
            rx_cnt_d = '0;
            rx_st_d  = R_IDLE;
            if (rx_s2_q) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_sh_q;
            end
         end else rx_cnt_d = rx_cnt_q + 1'b1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      op_cnt_d   = op_cnt_q;
      op_buf_d   = op_buf_q;
      gap_d      = gap_q;
      reg_addr_d = reg_addr_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      resp_d     = resp_q;
      left_d     = left_q;
      frame_d    = frame_q;
      tx_bit_d   = tx_bit_q;
      tx_cnt_d   = tx_cnt_q;
      fetch_go   = 1'b0;
      fetch_val  = 32'h0;
      fetch_left = 2'd0;
      case (state_q)
         S_IDLE: if (rx_valid_q) begin
            opcode_d = rx_data_q;
            op_cnt_d = '0;
            gap_d    = '0;
            state_d  = (rx_data_q == CMD_RDREG || rx_data_q == CMD_RDMEM) ? S_OPERAND : S_FETCH;
         end
         S_OPERAND: if (rx_valid_q) begin
            gap_d    = '0;
            op_buf_d = {rx_data_q, op_buf_q[23:8]};
            op_cnt_d = op_cnt_q + 2'd1;
            if (opcode_q == CMD_RDREG) begin
               reg_addr_d = rx_data_q[4:0];
               state_d    = S_FETCH;
            end else if (op_cnt_q == 2'd3) begin
               mem_addr_d = {rx_data_q, op_buf_q} & ~32'h3;
               mem_req_d  = 1'b1;
               state_d    = S_FETCH;
            end
         end else if (gap_q == GAP_END) state_d = S_IDLE;
         else gap_d = gap_q + 1'b1;
         S_FETCH: begin
            case (opcode_q)
               CMD_RDREG: begin fetch_go = 1'b1; fetch_val = dbg.dbg_reg_rdata; fetch_left = 2'd3; end
               CMD_RDPC:  begin fetch_go = 1'b1; fetch_val = dbg.dbg_pc;        fetch_left = 2'd3; end
               CMD_RDMEM: if (dbg.dbg_mem_ack) begin
                  fetch_go   = 1'b1;
                  fetch_val  = dbg.dbg_mem_rdata;
                  fetch_left = 2'd3;
                  mem_req_d  = 1'b0;
               end
               CMD_PING:  begin fetch_go = 1'b1; fetch_val = 32'h0000_00A5; end
               default:   begin fetch_go = 1'b1; fetch_val = 32'h0000_00EE; end
            endcase
            // Value is snapshotted here; later CPU changes do not reach the reply.
            if (fetch_go) begin
               state_d  = S_SEND;
               resp_d   = fetch_val[31:8];
               left_d   = fetch_left;
               frame_d  = {1'b1, fetch_val[7:0], 1'b0};
               tx_bit_d = '0;
               tx_cnt_d = '0;
            end
         end
         default: if (tx_cnt_q == BIT_END) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
               // Next frame loads on the stop bit's last cycle so bytes run back to back.
               if (left_q != 2'd0) begin
                  frame_d  = {1'b1, resp_q[7:0], 1'b0};
                  resp_d   = {8'h00, resp_q[23:8]};
                  left_d   = left_q - 2'd1;
                  tx_bit_d = '0;
               end else state_d = S_IDLE;
            end else begin
               frame_d  = {1'b1, frame_q[9:1]};
               tx_bit_d = tx_bit_q + 4'd1;
            end
         end else tx_cnt_d = tx_cnt_q + 1'b1;
      endcase
      uart_tx_d = (state_d == S_SEND) ? frame_d[0] : 1'b1;
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_s3_q <= 1'b1;
         rx_st_q <= R_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0;
         rx_sh_q <= '0; rx_data_q <= '0; rx_valid_q <= 1'b0;
         state_q <= S_IDLE; opcode_q <= '0; op_cnt_q <= '0; op_buf_q <= '0;
         gap_q <= '0; reg_addr_q <= '0; mem_req_q <= 1'b0; mem_addr_q <= '0;
         resp_q <= '0; left_q <= '0; frame_q <= '1; tx_bit_q <= '0; tx_cnt_q <= '0;
         uart_tx_q <= 1'b1; busy_q <= 1'b0;
      end else begin
         rx_s1_q <= rx_s1_d; rx_s2_q <= rx_s2_d; rx_s3_q <= rx_s3_d;
         rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d;
         rx_sh_q <= rx_sh_d; rx_data_q <= rx_data_d; rx_valid_q <= rx_valid_d;
         state_q <= state_d; opcode_q <= opcode_d; op_cnt_q <= op_cnt_d; op_buf_q <= op_buf_d;
         gap_q <= gap_d; reg_addr_q <= reg_addr_d; mem_req_q <= mem_req_d; mem_addr_q <= mem_addr_d;
         resp_q <= resp_d; left_q <= left_d; frame_q <= frame_d; tx_bit_q <= tx_bit_d; tx_cnt_q <= tx_cnt_d;
         uart_tx_q <= uart_tx_d; busy_q <= busy_d;
      end
   end

   assign uart_tx          = uart_tx_q;
   assign o_busy           = busy_q;
   assign dbg.dbg_reg_addr = reg_addr_q;
   assign dbg.dbg_mem_req  = mem_req_q;
   assign dbg.dbg_mem_addr = mem_addr_q;
endmodule
